tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive end of the 4:1 multiplexer path.
- Takes one time-division-multiplexed data line, carrying slots 0..3 in order, plus a frame sync marking slot 0.
- Tracks the slot position with an internal counter and an FSM, assembles each complete frame, and presents it on four registered channel outputs.
- Sits between the shared line and per-channel consumers; replaces the external select lines with recovered timing.

Parameters:
- WIDTH, 1, bit width of the data line and of each channel output.
- MISS_MAX, 2, consecutive missing syncs tolerated; used only with TDM_DEMUX_FREEWHEEL_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  slot strobe; din/sync sampled only when en=1.
- din  input  WIDTH  multiplexed data line.
- sync  input  1  high with the slot-0 sample of each frame.
- y0  output  WIDTH  channel 0, registered.
- y1  output  WIDTH  channel 1, registered.
- y2  output  WIDTH  channel 2, registered.
- y3  output  WIDTH  channel 3, registered.
- frame_valid  output  1  one-cycle pulse: y0..y3 just updated with a complete frame.
- slot  output  2  index of the next expected slot.
- locked  output  1  1 in LOCKED state.
- sync_err  output  1  one-cycle pulse on a sync violation.

Behaviour:
- Clocking and reset: single clock domain, reset synchronous active-high.
- Reset values: y0..y3=0, frame_valid=0, slot=0, locked=0, sync_err=0, shadow regs=0, miss count=0, state=HUNT.
- Reset mid-frame discards the partial frame; y0..y3 also clear to 0.
- Idle cycles: en=0 means no state change; frame_valid and sync_err are 0 on that cycle.
- HUNT state:
  - en=1 & sync=0: ignored.
  - en=1 & sync=1: shadow0<=din, slot<=1, state<=LOCKED.
- LOCKED, slot 1 or 2, en=1 & sync=0: shadow[slot]<=din, slot<=slot+1.
- LOCKED, slot 3, en=1 & sync=0:
  - y0<=shadow0, y1<=shadow1, y2<=shadow2, y3<=din.
  - frame_valid=1 for the following cycle only; outputs and pulse come from the same edge.
  - slot<=0.
- Latency: y* are valid in the cycle after the edge that samples the slot-3 strobe.
- LOCKED, slot 1..3, en=1 & sync=1 (early sync):
  - sync_err pulse.
  - Partial frame discarded; y* hold their values.
  - Resync: shadow0<=din, slot<=1, stay LOCKED.
- LOCKED, slot 0, en=1 & sync=1: normal start; shadow0<=din, slot<=1, miss count<=0.
- LOCKED, slot 0, en=1 & sync=0 (missing sync): sync_err pulse; handling depends on the optional feature.
- y* change only on frame completion and on reset.
- slot wraps 3->0 naturally; it is never any value outside 0..3.

Optional Feature:
- Macro: TDM_DEMUX_FREEWHEEL_EN.
- Defined:
  - A missing sync at slot 0 is treated as slot 0: shadow0<=din, slot<=1, miss count increments, state stays LOCKED.
  - The frame is still delivered normally.
  - When a miss would make miss count exceed MISS_MAX: state<=HUNT, slot<=0, locked<=0, that sample dropped.
  - A valid sync clears miss count.
  - sync_err pulses on every miss.
- Undefined:
  - Any missing sync: state<=HUNT, slot<=0, locked<=0, sample dropped.
  - No miss counter is built.

Test Plan:
- Reset then clean frame (WIDTH=1): assert rst 2 cycles, then en=1 each cycle, din=1,0,0,0 with sync on first -> one cycle after 4th sample y0=1,y1=0,y2=0,y3=0, frame_valid=1 for 1 cycle, locked=1, slot=0.
- Strobe gaps: same frame with en=0 between every sample -> identical outputs; frame_valid exactly one cycle; no change on en=0 cycles.
- Early sync: frame A=1,1,1,1 completes; next starts 0,0 then sync with din=1, then 0,1,0 -> sync_err pulse on resync; y* hold 1,1,1,1 until next completion, then read 1,0,1,0.
- Missing sync, macro undefined: after a good frame, slot-0 sample with sync=0 -> sync_err=1, locked=0, slot=0; subsequent samples ignored until sync=1.
- Missing sync, macro defined, MISS_MAX=2: two frames without sync -> both delivered, two sync_err pulses, locked stays 1. Third miss -> locked=0.
- Reset mid-frame: after 2 samples, rst=1 one cycle -> all outputs 0, state HUNT; next synced frame 0,1,1,0 -> y0..y3=0,1,1,0.

Source files
------------

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: recovers slot timing from the frame sync and
// delivers each complete frame on four registered channels. Define TDM_DEMUX_FREEWHEEL_EN
// to ride through up to MISS_MAX missing syncs instead of dropping lock on the first one.
module tdm_demux4 #(
    parameter int WIDTH    = 1,
    parameter int MISS_MAX = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shadow0_q, shadow0_d;
    logic [WIDTH-1:0] shadow1_q, shadow1_d;
    logic [WIDTH-1:0] shadow2_q, shadow2_d;
    logic [WIDTH-1:0] y0_q, y0_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic [WIDTH-1:0] y2_q, y2_d;
    logic [WIDTH-1:0] y3_q, y3_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;

`ifdef TDM_DEMUX_FREEWHEEL_EN
    localparam int MW = $clog2(MISS_MAX + 2);
    logic [MW-1:0] miss_q, miss_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            shadow2_q     <= '0;
            y0_q          <= '0;
            y1_q          <= '0;
            y2_q          <= '0;
            y3_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef TDM_DEMUX_FREEWHEEL_EN
            miss_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow0_q     <= shadow0_d;
            shadow1_q     <= shadow1_d;
            shadow2_q     <= shadow2_d;
            y0_q          <= y0_d;
            y1_q          <= y1_d;
            y2_q          <= y2_d;
            y3_q          <= y3_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
`ifdef TDM_DEMUX_FREEWHEEL_EN
            miss_q        <= miss_d;
`endif
        end
    end

    // Everything advances only on a strobed sample; idle cycles just let the pulses fall.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow0_d     = shadow0_q;
        shadow1_d     = shadow1_q;
        shadow2_d     = shadow2_q;
        y0_d          = y0_q;
        y1_d          = y1_q;
        y2_d          = y2_q;
        y3_d          = y3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
`ifdef TDM_DEMUX_FREEWHEEL_EN
        miss_d        = miss_q;
`endif
        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow0_d = din;
                        slot_d    = 2'd1;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // An early sync abandons the partial frame and restarts at slot 1.
                        shadow0_d = din;
                        slot_d    = 2'd1;
                        if (slot_q != 2'd0) begin
                            sync_err_d = 1'b1;
                        end else begin
`ifdef TDM_DEMUX_FREEWHEEL_EN
                            miss_d = '0;
`endif
                        end
                    end else begin
                        unique case (slot_q)
                            2'd0: begin
                                sync_err_d = 1'b1;
`ifdef TDM_DEMUX_FREEWHEEL_EN
                                if (miss_q >= MW'(MISS_MAX)) begin
                                    state_d = HUNT;
                                    slot_d  = 2'd0;
                                    miss_d  = '0;
                                end else begin
                                    shadow0_d = din;
                                    slot_d    = 2'd1;
                                    miss_d    = miss_q + MW'(1);
                                end
`else
                                state_d = HUNT;
                                slot_d  = 2'd0;
`endif
                            end
                            2'd1: begin
                                shadow1_d = din;
                                slot_d    = 2'd2;
                            end
                            2'd2: begin
                                shadow2_d = din;
                                slot_d    = 2'd3;
                            end
                            default: begin
                                y0_d          = shadow0_q;
                                y1_d          = shadow1_q;
                                y2_d          = shadow2_q;
                                y3_d          = din;
                                frame_valid_d = 1'b1;
                                slot_d        = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        y0          = y0_q;
        y1          = y1_q;
        y2          = y2_q;
        y3          = y3_q;
        frame_valid = frame_valid_q;
        sync_err    = sync_err_q;
        slot        = slot_q;
        locked      = (state_q == LOCKED);
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 (WIDTH=1): expected frames are queued as stimulus is
// driven and checked whenever frame_valid pulses; status outputs are checked inline.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [0:0] din = 1'b0;
    logic       sync = 1'b0;
    logic [0:0] y0, y1, y2, y3;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;

    int total = 0;
    int bad   = 0;
    int fv_count = 0;
    logic [3:0] exp_q[$];

    tdm_demux4 #(.WIDTH(1), .MISS_MAX(2)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: each frame_valid pulse consumes one queued frame {y0,y1,y2,y3}.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            logic [3:0] got;
            logic [3:0] want;
            fv_count++;
            got = {y0, y1, y2, y3};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL frame_unexpected got=%b required=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("[TB] FAIL frame_data got=%b required=%b", got, want);
                end
            end
        end
    end

    task automatic step(input logic e, input logic d, input logic s);
        @(negedge clk);
        en = e; din = d; sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        total++;
        if ({y0, y1, y2, y3, frame_valid, slot, locked, sync_err} !== 9'b0) begin
            bad++;
            $display("[TB] FAIL reset_state got=%b required=%b",
                     {y0, y1, y2, y3, frame_valid, slot, locked, sync_err}, 9'b0);
        end
    endtask

    task automatic test_clean_frame();
        int fv0;
        fv0 = fv_count;
        exp_q.push_back(4'b1000);
        step(1'b1, 1'b1, 1'b1);
        total++;
        if (locked !== 1'b1 || slot !== 2'd1) begin
            bad++;
            $display("[TB] FAIL lock_on_sync got=%b/%0d required=1/1", locked, slot);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        total++;
        if ({frame_valid, locked, slot} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL clean_complete got=%b required=%b", {frame_valid, locked, slot}, 4'b1100);
        end
        step(1'b0, 1'b0, 1'b0);
        total++;
        if (frame_valid !== 1'b0 || fv_count != fv0 + 1) begin
            bad++;
            $display("[TB] FAIL clean_pulse_width got=%b/%0d required=0/%0d", frame_valid, fv_count, fv0 + 1);
        end
    endtask

    task automatic test_strobe_gaps();
        logic [3:0] data;
        int fv0;
        data = 4'b0101;
        fv0 = fv_count;
        exp_q.push_back(data);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, data[3-i], (i == 0));
            step(1'b0, 1'b1, 1'b1);
            total++;
            if (slot !== 2'(i + 1) || frame_valid !== 1'b0 || locked !== 1'b1) begin
                bad++;
                $display("[TB] FAIL gap_idle_%0d got=%0d/%b/%b required=%0d/0/1",
                         i, slot, frame_valid, locked, 2'(i + 1));
            end
        end
        total++;
        if (fv_count != fv0 + 1 || {y0, y1, y2, y3} !== data) begin
            bad++;
            $display("[TB] FAIL gap_frame got=%0d/%b required=%0d/%b", fv_count, {y0, y1, y2, y3}, fv0 + 1, data);
        end
    endtask

    task automatic test_early_sync();
        exp_q.push_back(4'b1111);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (sync_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL early_no_err got=%b required=0", sync_err);
        end
        exp_q.push_back(4'b1010);
        step(1'b1, 1'b1, 1'b1);
        total++;
        if ({sync_err, locked, slot, y0, y1, y2, y3} !== 8'b1101_1111) begin
            bad++;
            $display("[TB] FAIL early_resync got=%b required=%b",
                     {sync_err, locked, slot, y0, y1, y2, y3}, 8'b1101_1111);
        end
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (sync_err !== 1'b0 || {y0, y1, y2, y3} !== 4'b1111) begin
            bad++;
            $display("[TB] FAIL early_hold got=%b/%b required=0/1111", sync_err, {y0, y1, y2, y3});
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (frame_valid !== 1'b1 || {y0, y1, y2, y3} !== 4'b1010) begin
            bad++;
            $display("[TB] FAIL early_next got=%b/%b required=1/1010", frame_valid, {y0, y1, y2, y3});
        end
    endtask

    task automatic test_missing_sync();
        exp_q.push_back(4'b1101);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
`ifdef TDM_DEMUX_FREEWHEEL_EN
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(4'b0110);
            step(1'b1, 1'b0, 1'b0);
            total++;
            if ({sync_err, locked, slot} !== 4'b1101) begin
                bad++;
                $display("[TB] FAIL freewheel_miss_%0d got=%b required=1101", f, {sync_err, locked, slot});
            end
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            total++;
            if (frame_valid !== 1'b1 || locked !== 1'b1) begin
                bad++;
                $display("[TB] FAIL freewheel_deliver_%0d got=%b/%b required=1/1", f, frame_valid, locked);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        total++;
        if ({sync_err, locked, slot} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL freewheel_drop got=%b required=1000", {sync_err, locked, slot});
        end
        exp_q.delete(exp_q.size() - 1);
        exp_q.push_back(4'b0110);
`else
        step(1'b1, 1'b1, 1'b0);
        total++;
        if ({sync_err, locked, slot} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL missing_drop got=%b required=1000", {sync_err, locked, slot});
        end
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'(i), 1'b0);
        end
        total++;
        if ({sync_err, locked, slot, frame_valid} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL missing_hunt got=%b required=00000", {sync_err, locked, slot, frame_valid});
        end
    endtask

    task automatic test_reset_mid_frame();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        total++;
        if ({y0, y1, y2, y3, frame_valid, slot, locked, sync_err} !== 9'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid got=%b required=%b",
                     {y0, y1, y2, y3, frame_valid, slot, locked, sync_err}, 9'b0);
        end
        step(1'b1, 1'b1, 1'b0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_hunt got=%b required=0", locked);
        end
        exp_q.push_back(4'b0110);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (frame_valid !== 1'b1 || {y0, y1, y2, y3} !== 4'b0110) begin
            bad++;
            $display("[TB] FAIL reset_next_frame got=%b/%b required=1/0110", frame_valid, {y0, y1, y2, y3});
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_strobe_gaps();
        test_early_sync();
        test_missing_sync();
        test_reset_mid_frame();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL frames_outstanding got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
